// File: rtl/if_fetch_stage.sv
// RV32 instruction fetch stage: owns the PC, issues credit-limited imem requests, queues responses in order.
// Build macro IF_MISALIGN_TRAP_EN: misaligned redirects go to TRAP_VECTOR and pulse misalign_trap.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned QUEUE_DEPTH = 2,
  parameter logic [31:0] TRAP_VECTOR = 32'h0000_0100
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        out_valid,
  output logic [31:0] out_pc_address,
  output logic [31:0] output_instruc
`ifdef IF_MISALIGN_TRAP_EN
  ,
  output logic        misalign_trap
`endif
);

  localparam int unsigned PW      = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CW      = PW + 1;
  localparam logic [CW:0] DEPTH_C = (CW + 1)'(QUEUE_DEPTH);
  localparam logic [31:0] NOP     = 32'h0000_0013;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_FLUSH = 1'b1} state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [31:0]   r_fetch_pc;
  logic [31:0]   w_fetch_pc_nxt;
  logic [CW-1:0] r_in_flight;
  logic [CW-1:0] r_drop_cnt;
  logic [CW-1:0] w_drop_nxt;
  logic [CW-1:0] r_q_cnt;
  logic [PW-1:0] r_q_rd;
  logic [PW-1:0] r_q_wr;
  logic [PW-1:0] r_t_rd;
  logic [PW-1:0] r_t_wr;
  logic [31:0]   r_q_pc  [QUEUE_DEPTH];
  logic [31:0]   r_q_ins [QUEUE_DEPTH];
  logic [31:0]   r_t_pc  [QUEUE_DEPTH];
  logic [31:0]   w_target;
  logic [CW:0]   w_occ;
  logic          w_grant;
  logic          w_pop;
  logic          w_push;
  logic          w_drop_resp;

`ifdef IF_MISALIGN_TRAP_EN
  logic w_misalign;
  logic r_trap;
  assign w_misalign    = (redirect_pc[1:0] != 2'b00);
  assign w_target      = w_misalign ? TRAP_VECTOR : redirect_pc;
  assign misalign_trap = r_trap;
`else
  logic w_unused;
  assign w_target = {redirect_pc[31:2], 2'b00};
  assign w_unused = ^{redirect_pc[1:0], TRAP_VECTOR};
`endif

  assign out_valid      = (r_q_cnt != {CW{1'b0}});
  assign out_pc_address = out_valid ? r_q_pc[r_q_rd] : 32'h0000_0000;
  assign output_instruc = out_valid ? r_q_ins[r_q_rd] : NOP;

  // A slot popped this cycle is already free, which keeps one fetch per cycle in steady state.
  assign w_pop       = out_valid & ~stall;
  assign w_occ       = {1'b0, r_in_flight} + {1'b0, r_q_cnt} - (CW + 1)'(w_pop);
  assign imem_req    = ~reset & (r_state == ST_RUN) & (w_occ < DEPTH_C);
  assign imem_addr   = r_fetch_pc;
  assign w_grant     = imem_req & imem_gnt;
  assign w_push      = imem_rvalid & ~redirect_valid & (r_drop_cnt == {CW{1'b0}});
  assign w_drop_resp = imem_rvalid & ~redirect_valid & (r_drop_cnt != {CW{1'b0}});

  // Next PC, wrong-path drop count and fetch FSM state.
  always_comb begin
    w_fetch_pc_nxt = r_fetch_pc;
    w_drop_nxt     = r_drop_cnt;
    w_state_nxt    = r_state;
    if (redirect_valid) begin
      w_fetch_pc_nxt = w_target;
      w_drop_nxt     = r_in_flight + CW'(w_grant) - CW'(imem_rvalid);
      w_state_nxt    = (w_drop_nxt != {CW{1'b0}}) ? ST_FLUSH : ST_RUN;
    end else begin
      if (w_grant) begin
        w_fetch_pc_nxt = r_fetch_pc + 32'd4;
      end else begin
        w_fetch_pc_nxt = r_fetch_pc;
      end
      if (w_drop_resp) begin
        w_drop_nxt = r_drop_cnt - CW'(1);
      end else begin
        w_drop_nxt = r_drop_cnt;
      end
      case (r_state)
        ST_RUN:   w_state_nxt = ST_RUN;
        ST_FLUSH: w_state_nxt = (w_drop_nxt == {CW{1'b0}}) ? ST_RUN : ST_FLUSH;
        default:  w_state_nxt = ST_RUN;
      endcase
    end
  end

  // Control state: PC, counters, FSM and queue pointers.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_RUN;
      r_fetch_pc  <= RESET_PC;
      r_in_flight <= {CW{1'b0}};
      r_drop_cnt  <= {CW{1'b0}};
      r_q_cnt     <= {CW{1'b0}};
      r_q_rd      <= {PW{1'b0}};
      r_q_wr      <= {PW{1'b0}};
      r_t_rd      <= {PW{1'b0}};
      r_t_wr      <= {PW{1'b0}};
    end else begin
      r_state     <= w_state_nxt;
      r_fetch_pc  <= w_fetch_pc_nxt;
      r_in_flight <= r_in_flight + CW'(w_grant) - CW'(imem_rvalid);
      r_drop_cnt  <= w_drop_nxt;
      if (w_grant) r_t_wr <= r_t_wr + PW'(1);
      if (imem_rvalid) r_t_rd <= r_t_rd + PW'(1);
      if (redirect_valid) begin
        r_q_cnt <= {CW{1'b0}};
        r_q_rd  <= {PW{1'b0}};
        r_q_wr  <= {PW{1'b0}};
      end else begin
        if (w_push) r_q_wr <= r_q_wr + PW'(1);
        if (w_pop) r_q_rd <= r_q_rd + PW'(1);
        r_q_cnt <= r_q_cnt + CW'(w_push) - CW'(w_pop);
      end
    end
  end

  // Storage: tag PCs of outstanding requests and the returned {PC, instruction} entries.
  always_ff @(posedge clock) begin
    if (w_grant) r_t_pc[r_t_wr] <= r_fetch_pc;
    if (w_push) begin
      r_q_pc[r_q_wr]  <= r_t_pc[r_t_rd];
      r_q_ins[r_q_wr] <= imem_rdata;
    end
  end

`ifdef IF_MISALIGN_TRAP_EN
  // One-cycle trap pulse following a misaligned redirect.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_trap <= 1'b0;
    end else begin
      r_trap <= redirect_valid & w_misalign;
    end
  end
`endif

endmodule
